// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  // 125 MHz system clock at 115200 baud.
  localparam int unsigned DEFAULT_BAUD_DIV = 1085;

  // Parity of a payload zero-extended to 8 bits; odd parity inverts the XOR.
  function automatic logic parity_bit(input logic [7:0] data, input int unsigned par);
    return (^data) ^ (par == PAR_ODD);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers, occupancy count and full/empty flags.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [WIDTH-1:0]        wdata_i,
  output logic [WIDTH-1:0]        rdata_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q, count_d;
  logic             full_q, empty_q;
  logic             push_ok, pop_ok;

  // A push is gated only by the registered full flag, independent of a same-cycle pop.
  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && !empty_q;

  // Occupancy next-state; push and pop together leave the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PtrW+1)'(1);
      2'b01:   count_d = count_q - (PtrW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers, count and flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
      full_q  <= (count_d == (PtrW+1)'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage; a pop from the slot being written still sees the old entry.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO front end feeding a start/data/parity/stop serialiser.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV  = DEFAULT_BAUD_DIV,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = PAR_NONE,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        wr_en,
  input  logic [DATA_BITS-1:0]        wr_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        busy,
  output logic                        overflow,
  input  logic                        clr_overflow,
  output logic                        uart_tx
);

  localparam int unsigned BaudW = $clog2(BAUD_DIV);

  tx_state_e            state_q, state_d;
  logic [BaudW-1:0]     baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 ovf_q, ovf_d;
  logic                 pop;
  logic                 baud_wrap;
  logic [DATA_BITS-1:0] fifo_rdata;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (wr_en),
    .pop_i   (pop),
    .wdata_i (wr_data),
    .rdata_o (fifo_rdata),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign baud_wrap = (baud_q == BaudW'(BAUD_DIV - 1));

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next state, baud/bit counters, shift register and FIFO pop.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    if (state_q != StIdle) baud_d = baud_wrap ? '0 : baud_q + BaudW'(1);
    case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = StStart;
          baud_d  = '0;
        end
      end
      StStart: begin
        if (baud_wrap) begin
          state_d = StData;
          bit_d   = '0;
        end
      end
      StData: begin
        if (baud_wrap) begin
          shift_d = shift_q >> 1;
          if (bit_q == 3'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != PAR_NONE) ? StParity : StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (baud_wrap) begin
          state_d = StStop;
          bit_d   = '0;
        end
      end
      StStop: begin
        if (baud_wrap) begin
          if (bit_q == 3'(STOP_BITS - 1)) begin
            bit_d = '0;
            // Chain straight into the next start bit when more data is waiting.
            if (!empty) begin
              pop     = 1'b1;
              state_d = StStart;
            end else begin
              state_d = StIdle;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (pop) begin
      shift_d = fifo_rdata;
      par_d   = parity_bit(8'(fifo_rdata), PARITY);
    end
  end

  // Registered line and busy outputs, decoded from the upcoming state.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != StIdle);
  end

  // Sticky overflow; a dropped push outranks a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_overflow) ovf_d = 1'b0;
    if (wr_en && full) ovf_d = 1'b1;
  end

  assign uart_tx  = tx_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three differently configured instances checked every cycle
// against a queue-based model of FIFO contents and the expected serial waveform.
module tb_uart_tx_fifo;

  localparam int NI = 3;

  // Instance 0: 8N1, instance 1: 7O2, instance 2: 5E1.
  localparam int unsigned A_BAUD = 4, A_DEPTH = 4, A_BITS = 8, A_PAR = 0, A_STOP = 1;
  localparam int unsigned B_BAUD = 3, B_DEPTH = 8, B_BITS = 7, B_PAR = 2, B_STOP = 2;
  localparam int unsigned C_BAUD = 2, C_DEPTH = 2, C_BITS = 5, C_PAR = 1, C_STOP = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]      rst_r = '1;
  logic [NI-1:0]      wr_en_r = '0;
  logic [NI-1:0]      clr_r = '0;
  logic [NI-1:0][7:0] wr_data_r = '0;
  logic [NI-1:0]      tx_w, busy_w, full_w, empty_w, ovf_w;
  logic [2:0]         cnt0;
  logic [3:0]         cnt1;
  logic [1:0]         cnt2;

  uart_tx_fifo #(
    .BAUD_DIV(A_BAUD), .DEPTH(A_DEPTH), .DATA_BITS(A_BITS), .PARITY(A_PAR), .STOP_BITS(A_STOP)
  ) u_dut0 (
    .CLK(clk), .RST(rst_r[0]), .wr_en(wr_en_r[0]), .wr_data(wr_data_r[0][7:0]),
    .full(full_w[0]), .empty(empty_w[0]), .count(cnt0), .busy(busy_w[0]),
    .overflow(ovf_w[0]), .clr_overflow(clr_r[0]), .uart_tx(tx_w[0])
  );

  uart_tx_fifo #(
    .BAUD_DIV(B_BAUD), .DEPTH(B_DEPTH), .DATA_BITS(B_BITS), .PARITY(B_PAR), .STOP_BITS(B_STOP)
  ) u_dut1 (
    .CLK(clk), .RST(rst_r[1]), .wr_en(wr_en_r[1]), .wr_data(wr_data_r[1][6:0]),
    .full(full_w[1]), .empty(empty_w[1]), .count(cnt1), .busy(busy_w[1]),
    .overflow(ovf_w[1]), .clr_overflow(clr_r[1]), .uart_tx(tx_w[1])
  );

  uart_tx_fifo #(
    .BAUD_DIV(C_BAUD), .DEPTH(C_DEPTH), .DATA_BITS(C_BITS), .PARITY(C_PAR), .STOP_BITS(C_STOP)
  ) u_dut2 (
    .CLK(clk), .RST(rst_r[2]), .wr_en(wr_en_r[2]), .wr_data(wr_data_r[2][4:0]),
    .full(full_w[2]), .empty(empty_w[2]), .count(cnt2), .busy(busy_w[2]),
    .overflow(ovf_w[2]), .clr_overflow(clr_r[2]), .uart_tx(tx_w[2])
  );

  function automatic int unsigned baud_of(input int i);
    return (i == 0) ? A_BAUD : (i == 1) ? B_BAUD : C_BAUD;
  endfunction
  function automatic int unsigned depth_of(input int i);
    return (i == 0) ? A_DEPTH : (i == 1) ? B_DEPTH : C_DEPTH;
  endfunction
  function automatic int unsigned bits_of(input int i);
    return (i == 0) ? A_BITS : (i == 1) ? B_BITS : C_BITS;
  endfunction
  function automatic int unsigned par_of(input int i);
    return (i == 0) ? A_PAR : (i == 1) ? B_PAR : C_PAR;
  endfunction
  function automatic int unsigned stop_of(input int i);
    return (i == 0) ? A_STOP : (i == 1) ? B_STOP : C_STOP;
  endfunction
  function automatic logic [31:0] cnt_of(input int i);
    return (i == 0) ? 32'(cnt0) : (i == 1) ? 32'(cnt1) : 32'(cnt2);
  endfunction

  // Model: bytes waiting in the FIFO, and the line levels still to be driven (one per cycle,
  // head = level on the line this cycle; empty queue = idle).
  logic [7:0] fifo_m [NI][$];
  bit         lvl_m  [NI][$];
  bit         ovf_m  [NI];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic add_level(input int i, input bit level, input int unsigned n);
    for (int k = 0; k < int'(n); k++) lvl_m[i].push_back(level);
  endtask

  task automatic build_frame(input int i, input logic [7:0] b);
    int unsigned bd;
    bd = baud_of(i);
    add_level(i, 1'b0, bd);
    for (int j = 0; j < int'(bits_of(i)); j++) add_level(i, b[j], bd);
    if (par_of(i) != 0) add_level(i, (^b) ^ (par_of(i) == 2), bd);
    add_level(i, 1'b1, stop_of(i) * bd);
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step(input int i);
    int  sz;
    bit  accept, popping;
    logic [7:0] mask;
    if (rst_r[i]) begin
      fifo_m[i].delete();
      lvl_m[i].delete();
      ovf_m[i] = 1'b0;
      return;
    end
    mask    = 8'((1 << bits_of(i)) - 1);
    sz      = lvl_m[i].size();
    accept  = wr_en_r[i] && (fifo_m[i].size() < int'(depth_of(i)));
    // A new frame starts when idle or on the very last cycle of the current frame.
    popping = (fifo_m[i].size() > 0) && (sz <= 1);
    if (sz > 0) void'(lvl_m[i].pop_front());
    if (popping) build_frame(i, fifo_m[i].pop_front());
    if (accept) fifo_m[i].push_back(wr_data_r[i] & mask);
    if (wr_en_r[i] && !accept) ovf_m[i] = 1'b1;
    else if (clr_r[i]) ovf_m[i] = 1'b0;
  endtask

  task automatic compare(input int i);
    int  sz;
    bit  exp_tx;
    sz     = fifo_m[i].size();
    exp_tx = (lvl_m[i].size() > 0) ? lvl_m[i][0] : 1'b1;
    check_eq($sformatf("u%0d.uart_tx@%0d", i, cyc), 32'(tx_w[i]), 32'(exp_tx));
    check_eq($sformatf("u%0d.busy@%0d", i, cyc), 32'(busy_w[i]), 32'(lvl_m[i].size() > 0));
    check_eq($sformatf("u%0d.count@%0d", i, cyc), cnt_of(i), 32'(sz));
    check_eq($sformatf("u%0d.full@%0d", i, cyc), 32'(full_w[i]), 32'(sz == int'(depth_of(i))));
    check_eq($sformatf("u%0d.empty@%0d", i, cyc), 32'(empty_w[i]), 32'(sz == 0));
    check_eq($sformatf("u%0d.overflow@%0d", i, cyc), 32'(ovf_w[i]), 32'(ovf_m[i]));
  endtask

  // One clock: model follows the edge, pulse inputs drop, then every output is compared.
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < NI; i++) model_step(i);
    #1;
    wr_en_r = '0;
    clr_r   = '0;
    rst_r   = '0;
    cyc++;
    for (int i = 0; i < NI; i++) compare(i);
  endtask

  task automatic push(input int i, input logic [7:0] d);
    wr_en_r[i]   = 1'b1;
    wr_data_r[i] = d;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int busy_cnt;

    // Reset all instances.
    rst_r = '1;
    tick();
    rst_r = '1;
    tick();

    // 0x55 on 8N1: start at cycle 2, alternating bits of 4 cycles, busy for 40 cycles.
    push(0, 8'h55);
    tick();
    tick();
    check_eq("lat_tx_low", 32'(tx_w[0]), 32'd0);
    check_eq("lat_busy", 32'(busy_w[0]), 32'd1);
    check_eq("lat_empty", 32'(empty_w[0]), 32'd1);
    for (int b = 0; b < 10; b++) begin
      check_eq($sformatf("seq55_bit%0d", b), 32'(tx_w[0]), 32'(b & 1));
      run(4);
    end
    check_eq("seq55_busy_end", 32'(busy_w[0]), 32'd0);
    run(4);

    // Three consecutive pushes: 120 busy cycles with no gap.
    busy_cnt = 0;
    push(0, 8'h01);
    tick();
    push(0, 8'h02);
    tick();
    push(0, 8'h03);
    tick();
    for (int k = 0; k < 125; k++) begin
      tick();
      if (busy_w[0]) busy_cnt++;
    end
    check_eq("b2b_busy_cycles", 32'(busy_cnt), 32'd118);

    // Six pushes into DEPTH=4: five accepted, sixth sets overflow.
    for (int k = 0; k < 6; k++) begin
      push(0, 8'(k));
      tick();
      if (k == 4) begin
        check_eq("ovf_fill_count", cnt_of(0), 32'd4);
        check_eq("ovf_fill_full", 32'(full_w[0]), 32'd1);
      end
    end
    check_eq("ovf_set", 32'(ovf_w[0]), 32'd1);
    // Push while full together with clear: overflow must stay set.
    push(0, 8'hEE);
    clr_r[0] = 1'b1;
    tick();
    check_eq("ovf_set_wins", 32'(ovf_w[0]), 32'd1);
    clr_r[0] = 1'b1;
    tick();
    check_eq("ovf_cleared", 32'(ovf_w[0]), 32'd0);
    run(220);

    // 0x07 on 7O2 (parity 0, 33-cycle frame) and on 5E1 (parity 1).
    push(1, 8'h07);
    push(2, 8'h07);
    tick();
    for (int t = 2; t <= 40; t++) begin
      tick();
      if (t == 14) check_eq("even_parity_bit", 32'(tx_w[2]), 32'd1);
      if (t == 26) check_eq("odd_parity_bit", 32'(tx_w[1]), 32'd0);
      if (t == 34) check_eq("frame11_last", 32'(busy_w[1]), 32'd1);
      if (t == 35) check_eq("frame11_done", 32'(busy_w[1]), 32'd0);
    end

    // Reset in the data phase with bytes queued, then a fresh frame.
    for (int k = 0; k < 3; k++) begin
      push(1, 8'h30 + 8'(k));
      tick();
    end
    run(8);
    rst_r[1] = 1'b1;
    tick();
    check_eq("rst_tx", 32'(tx_w[1]), 32'd1);
    check_eq("rst_count", cnt_of(1), 32'd0);
    check_eq("rst_busy", 32'(busy_w[1]), 32'd0);
    push(1, 8'h2A);
    tick();
    run(40);

    // Randomised traffic with bursty load, occasional clears and resets.
    for (int t = 0; t < 2400; t++) begin
      int rate;
      rate = ((t / 400) % 3 == 0) ? 8 : (((t / 400) % 3 == 1) ? 40 : 95);
      for (int i = 0; i < NI; i++) begin
        wr_en_r[i]   = ($urandom_range(0, 99) < rate);
        wr_data_r[i] = 8'($urandom);
        clr_r[i]     = ($urandom_range(0, 99) < 3);
        rst_r[i]     = ($urandom_range(0, 999) < 2);
      end
      tick();
    end
    run(400);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
